// File: rtl/memory_write_buffer.sv
// memory_write_buffer: in-order store buffer between the CPU datapath and the
// memory write port. Stores with non-zero byte enables are queued in a small
// FIFO and drained one at a time over a req/ack handshake.
//
// Handshakes:
//   store side  - a store transfers on any rising edge where st_valid && st_ready.
//                 st_ready depends only on count, so a full buffer stays closed
//                 for the whole cycle even if memory drains an entry that cycle.
//   memory side - mem_req/mem_addr/mem_wdata/mem_be come straight from the head
//                 entry; a write completes on an edge where mem_req && mem_ack.
//                 mem_ack with mem_req low is ignored. The payload never changes
//                 while a write is pending.
module memory_write_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_WIDTH-1:0]      st_addr,
    input  logic [DATA_WIDTH-1:0]      st_data,
    input  logic [DATA_WIDTH/8-1:0]    st_be,
    output logic                       mem_req,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic [DATA_WIDTH/8-1:0]    mem_be,
    input  logic                       mem_ack,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Entry storage; contents are don't-care until count covers them.
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [BW-1:0]         be_mem   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // A zero-BE store completes its handshake but writes nothing, so it is
    // simply not enqueued.
    assign st_ready  = (count != FULL_COUNT);
    assign push      = st_valid && st_ready && (st_be != '0);
    assign empty     = (count == '0);
    assign mem_req   = !empty;
    assign pop       = mem_req && mem_ack;
    assign mem_addr  = addr_mem[rd_ptr];
    assign mem_wdata = data_mem[rd_ptr];
    assign mem_be    = be_mem[rd_ptr];

    // Write the accepted store into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= st_addr;
            data_mem[wr_ptr] <= st_data;
            be_mem[wr_ptr]   <= st_be;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards every pending entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_memory_write_buffer.sv
// Directed bench for memory_write_buffer (DATA_WIDTH=32, ADDR_WIDTH=32, DEPTH=4).
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_memory_write_buffer;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = 4;
  localparam int EW = AW + DW + BW;

  logic          clk;
  logic          reset;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [BW-1:0] st_be;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ack;
  logic          empty;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  memory_write_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .empty(empty), .count(count)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: present a store for one cycle
  task automatic drive_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = b;
    tick();
    st_valid = 1'b0;
  endtask

  // scoreboard: ack until mem_req drops, checking each write against exp_q
  task automatic drain(input string tag, input int max_cycles);
    logic [EW-1:0] e;
    mem_ack = 1'b1;
    for (int n = 0; n < max_cycles && mem_req === 1'b1; n++) begin
      chk({tag, "_write_expected"}, EW'(exp_q.size() != 0), EW'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({tag, "_payload"}, {mem_addr, mem_wdata, mem_be}, e);
      end
      tick();
    end
    mem_ack = 1'b0;
    chk({tag, "_drained_req"}, EW'(mem_req), EW'(0));
    chk({tag, "_missing_writes"}, EW'(exp_q.size()), EW'(0));
  endtask

  initial begin
    logic [EW-1:0] e;
    reset    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_be    = '0;
    mem_ack  = 1'b0;
    tick();

    // reset state; a push attempted during reset is discarded
    chk("rst_count", EW'(count), EW'(0));
    chk("rst_empty", EW'(empty), EW'(1));
    chk("rst_mem_req", EW'(mem_req), EW'(0));
    chk("rst_st_ready", EW'(st_ready), EW'(1));
    drive_store(32'h0000_0999, 32'h1111_2222, 4'hF);
    chk("rst_push_discarded", EW'(count), EW'(0));
    reset = 1'b1;
    tick();
    chk("post_rst_req", EW'(mem_req), EW'(0));

    // single store, stalled for 5 cycles, then one ack
    drive_store(32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    exp_q.push_back({32'h0000_0100, 32'hDEAD_BEEF, 4'hF});
    chk("single_req", EW'(mem_req), EW'(1));
    chk("single_count", EW'(count), EW'(1));
    chk("single_payload", {mem_addr, mem_wdata, mem_be}, {32'h0000_0100, 32'hDEAD_BEEF, 4'hF});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("single_stall_payload", {mem_addr, mem_wdata, mem_be}, {32'h0000_0100, 32'hDEAD_BEEF, 4'hF});
    end
    mem_ack = 1'b1;
    e = exp_q.pop_front();
    chk("single_ack_payload", {mem_addr, mem_wdata, mem_be}, e);
    tick();
    mem_ack = 1'b0;
    chk("single_empty", EW'(empty), EW'(1));
    chk("single_req_low", EW'(mem_req), EW'(0));

    // stray ack with nothing pending is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_count", EW'(count), EW'(0));

    // fill to full: 5 stores on consecutive cycles, only 4 fit
    for (int i = 1; i <= 5; i++) begin
      st_valid = 1'b1;
      st_addr  = 32'h0000_0200 + 32'(i);
      st_data  = 32'(i);
      st_be    = 4'hF;
      if (i <= 4) begin
        chk("fill_ready", EW'(st_ready), EW'(1));
        exp_q.push_back({32'h0000_0200 + 32'(i), 32'(i), 4'hF});
        tick();
        chk("fill_count", EW'(count), EW'(i));
      end else begin
        chk("full_ready_low", EW'(st_ready), EW'(0));
        chk("full_count", EW'(count), EW'(4));
      end
    end
    // full with ack and st_valid in the same cycle: pop only
    mem_ack = 1'b1;
    e = exp_q.pop_front();
    chk("full_ack_head", {mem_addr, mem_wdata, mem_be}, e);
    tick();
    chk("full_ack_count", EW'(count), EW'(3));
    chk("full_ack_ready", EW'(st_ready), EW'(1));
    // the held 5th store is taken now, alongside another pop
    e = exp_q.pop_front();
    chk("fill_head2", {mem_addr, mem_wdata, mem_be}, e);
    exp_q.push_back({32'h0000_0205, 32'd5, 4'hF});
    tick();
    st_valid = 1'b0;
    chk("fill_push5_count", EW'(count), EW'(3));
    drain("fill", 20);

    // steady push/pop at count=2 for 10 cycles (wraps the pointers)
    drive_store(32'h0000_0300, 32'h30, 4'hF);
    exp_q.push_back({32'h0000_0300, 32'h30, 4'hF});
    drive_store(32'h0000_0301, 32'h31, 4'hF);
    exp_q.push_back({32'h0000_0301, 32'h31, 4'hF});
    chk("stream_start_count", EW'(count), EW'(2));
    mem_ack  = 1'b1;
    st_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      st_addr = 32'h0000_0400 + 32'(k);
      st_data = 32'h40 + 32'(k);
      st_be   = 4'(k + 1);
      e = exp_q.pop_front();
      chk("stream_head", {mem_addr, mem_wdata, mem_be}, e);
      exp_q.push_back({st_addr, st_data, st_be});
      tick();
      chk("stream_count", EW'(count), EW'(2));
    end
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    drain("stream", 10);

    // zero byte enable store is handshaked but not queued
    drive_store(32'h0000_0500, 32'hA1, 4'h3);
    exp_q.push_back({32'h0000_0500, 32'hA1, 4'h3});
    chk("zbe_count1", EW'(count), EW'(1));
    st_valid = 1'b1;
    st_addr  = 32'h0000_0BAD;
    st_data  = 32'hBAD;
    st_be    = 4'h0;
    chk("zbe_ready", EW'(st_ready), EW'(1));
    tick();
    st_valid = 1'b0;
    chk("zbe_count_unchanged", EW'(count), EW'(1));
    drive_store(32'h0000_0501, 32'hA2, 4'h3);
    exp_q.push_back({32'h0000_0501, 32'hA2, 4'h3});
    chk("zbe_count2", EW'(count), EW'(2));
    drain("zbe", 10);

    // reset mid-operation with 3 entries pending
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h0000_0600 + 32'(i), 32'h60 + 32'(i), 4'hF);
    end
    chk("midrst_pre_count", EW'(count), EW'(3));
    chk("midrst_pre_req", EW'(mem_req), EW'(1));
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_req", EW'(mem_req), EW'(0));
    chk("midrst_count", EW'(count), EW'(0));
    chk("midrst_empty", EW'(empty), EW'(1));
    tick();
    reset = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_stale", EW'(mem_req), EW'(0));
    end
    mem_ack = 1'b0;
    drive_store(32'h0000_0700, 32'hCAFE_F00D, 4'h5);
    exp_q.push_back({32'h0000_0700, 32'hCAFE_F00D, 4'h5});
    chk("midrst_new_count", EW'(count), EW'(1));
    drain("midrst_new", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_write_buffer.md
# memory_write_buffer

Store-side counterpart to the CPU's memory data register: the register captures data returning from memory, and this block carries CPU store data out to memory. It accepts store requests (address, data, byte enables) from the CPU datapath into a small in-order FIFO. It drains each entry to the memory port over a req/ack handshake, so the CPU can continue while memory is slow.

## Interface
- DATA_WIDTH, 32, store data width; multiple of 8
- ADDR_WIDTH, 32, store address width
- DEPTH, 4, FIFO entries; power of 2, at least 2
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; 0 = in reset
- st_valid  input  1  CPU presents a store
- st_ready  output  1  buffer can accept a store this cycle
- st_addr  input  ADDR_WIDTH  store address
- st_data  input  DATA_WIDTH  store data
- st_be  input  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i]
- mem_req  output  1  head entry is presented to memory
- mem_addr  output  ADDR_WIDTH  head entry address
- mem_wdata  output  DATA_WIDTH  head entry data
- mem_be  output  DATA_WIDTH/8  head entry byte enables
- mem_ack  input  1  memory accepts the presented write this cycle
- empty  output  1  no entries held
- count  output  $clog2(DEPTH+1)  number of entries held

## Operation
- Storage: DEPTH entries of {addr, data, be}, with write pointer, read pointer and count.
  - Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Push: a store is accepted when st_valid && st_ready.
  - If st_be != 0, the entry is written at the write pointer, and the write pointer and count increment.
  - If st_be == 0, the handshake completes but nothing is enqueued; state is unchanged.
- st_ready = (count != DEPTH). It is combinational from count only and is independent of mem_ack in the same cycle.
- mem_req = !empty. mem_addr, mem_wdata and mem_be are driven from the entry at the read pointer.
- Pop: when mem_req && mem_ack, the read pointer increments and count decrements.
- mem_ack while mem_req = 0 is ignored.
- Simultaneous push and pop (count neither 0 nor DEPTH): both pointers advance and count is unchanged.
- Full (count == DEPTH): st_ready = 0. No push occurs even if a pop happens that cycle; st_ready rises the following cycle.
- Empty with a push: the entry is not forwarded combinationally. mem_req rises the next cycle.
- Ordering: strictly FIFO. Every accepted non-zero-BE store reaches memory exactly once, in acceptance order.
- empty = (count == 0).

## Timing
- Reset asserted (reset = 0), asynchronously:
  - pointers = 0, count = 0, empty = 1, mem_req = 0
  - st_ready = 1, but pushes during reset are discarded
  - storage contents need not be cleared
- Reset asserted mid-operation discards all pending entries. mem_req drops in the same cycle without waiting for mem_ack.
- Push-to-memory latency: a store accepted at edge N produces mem_req = 1 with its payload after edge N, provided the buffer was empty.
- Payload stability: while mem_req = 1 and mem_ack = 0, mem_addr, mem_wdata and mem_be hold constant. Pushes into other entries do not disturb the head.
- Back-to-back: with mem_ack held at 1, one entry drains per cycle. A continuous push stream at one store per cycle then sustains full throughput with count constant.
- count and empty reflect post-edge state. There is no combinational path from st_valid or mem_ack to any output.

## Test plan
- Reset then single store: push addr=0x100, data=0xDEADBEEF, be=0xF with mem_ack=0.
  - Next cycle: mem_req=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_be=0xF, count=1.
  - Payload holds for 5 stall cycles. Ack for one cycle, then empty=1 and mem_req=0.
- Fill to full: with mem_ack=0, push 5 stores, data 1..5, on consecutive cycles.
  - The first 4 are accepted; count=4 and st_ready=0 on the 5th.
  - Release ack: writes emerge with data 1,2,3,4 in order. The 5th is accepted once st_ready=1.
- Simultaneous push/pop at count=2 with mem_ack=1 and st_valid=1 for 10 cycles: count stays 2, and the memory sequence equals the push sequence. This exercises pointer wrap past DEPTH-1.
- Full plus ack in the same cycle: at count=4, assert mem_ack=1 and st_valid=1.
  - That cycle: no push, count becomes 3.
  - Next cycle: st_ready=1 and the push is accepted.
- Zero byte enable: push be=0x0 between two be=0x3 stores. The handshake completes, but only the two be=0x3 writes appear on the memory side and count never exceeds 2.
- Reset mid-operation: with 3 entries pending and mem_req=1, pull reset low mid-cycle.
  - Immediately: mem_req=0, count=0, empty=1.
  - After release: no stale writes appear, and a new store drains correctly.
